// File: rtl/hazard_scoreboard.sv
// Hazard unit: N-source operand forwarding, load-use / scoreboard / structural
// stall generation, and a one-deep countdown scoreboard for a long (mul/div) op.
module hazard_scoreboard #(
  parameter int REG_W      = 5,
  parameter int FWD_STAGES = 2,
  parameter int LAT_W      = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [FWD_STAGES-1:0]       FWD_rd_rw,
  input  logic [FWD_STAGES*REG_W-1:0] FWD_rd,
  input  logic [REG_W-1:0]            EXEC_rs1,
  input  logic [REG_W-1:0]            EXEC_rs2,
  output logic [FWD_STAGES-1:0]       FWD_rs1,
  output logic [FWD_STAGES-1:0]       FWD_rs2,
  input  logic [REG_W-1:0]            IF_ID_rs1,
  input  logic [REG_W-1:0]            IF_ID_rs2,
  input  logic [REG_W-1:0]            IF_ID_rd,
  input  logic                        ID_rd_rw,
  input  logic                        ID_lop,
  input  logic [REG_W-1:0]            EXEC_rd,
  input  logic                        EXEC_mem_read,
  input  logic                        BRA_mispredict,
  input  logic                        JMP_ctrl,
  input  logic                        IF_valid,
  input  logic                        MEM_valid,
  input  logic                        issue_valid,
  input  logic [REG_W-1:0]            issue_rd,
  input  logic [LAT_W-1:0]            issue_lat,
  output logic                        IF_stall,
  output logic                        IF_ID_stall,
  output logic                        EXEC_MEM_stall,
  output logic                        IF_ID_flush,
  output logic                        EXEC_MEM_flush,
  output logic                        ctrlBubble,
  output logic                        lop_busy,
  output logic                        lop_done,
  output logic [REG_W-1:0]            lop_rd
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} lop_state_t;

  localparam logic [LAT_W-1:0] CNT_ZERO = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0] CNT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [REG_W-1:0] X0       = {REG_W{1'b0}};

  lop_state_t       state_r;
  logic [LAT_W-1:0] cnt_r;
  logic [REG_W-1:0] lop_rd_r;

  logic             busy_s;
  logic             done_s;
  logic             accept_s;
  logic [LAT_W-1:0] lat_eff_s;
  logic             load_stall_s;
  logic             sb_stall_s;
  logic             st_stall_s;
  logic             hold_s;

  // Youngest matching source wins; x0 is hard-wired and never forwarded.
  function automatic logic [FWD_STAGES-1:0] fwd_select(
    input logic [REG_W-1:0]            src,
    input logic [FWD_STAGES-1:0]       rw,
    input logic [FWD_STAGES*REG_W-1:0] rd
  );
    logic [FWD_STAGES-1:0] sel;
    logic                  found;
    logic                  hit;
    sel   = {FWD_STAGES{1'b0}};
    found = 1'b0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      hit    = rw[k] && (rd[k*REG_W +: REG_W] == src) && (src != X0);
      sel[k] = hit && !found;
      found  = found || hit;
    end
    return sel;
  endfunction

  // Destination write is included so a WAW on the long-op target also holds.
  function automatic logic id_touches(
    input logic [REG_W-1:0] r,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic [REG_W-1:0] rd,
    input logic             rd_rw
  );
    return (rs1 == r) || (rs2 == r) || (rd_rw && (rd == r));
  endfunction

  assign FWD_rs1 = fwd_select(EXEC_rs1, FWD_rd_rw, FWD_rd);
  assign FWD_rs2 = fwd_select(EXEC_rs2, FWD_rd_rw, FWD_rd);

  assign busy_s    = (state_r == BUSY);
  assign done_s    = busy_s && (cnt_r == CNT_ONE);
  assign accept_s  = issue_valid && !BRA_mispredict && (!busy_s || done_s);
  assign lat_eff_s = (issue_lat == CNT_ZERO) ? CNT_ONE : issue_lat;

  assign load_stall_s = EXEC_mem_read && (EXEC_rd != X0) &&
                        ((IF_ID_rs1 == EXEC_rd) || (IF_ID_rs2 == EXEC_rd));

  // The register is released in the done cycle itself (write-through regfile).
  assign sb_stall_s =
      (busy_s && !done_s &&
       id_touches(lop_rd_r, IF_ID_rs1, IF_ID_rs2, IF_ID_rd, ID_rd_rw)) ||
      (accept_s && (issue_rd != X0) &&
       id_touches(issue_rd, IF_ID_rs1, IF_ID_rs2, IF_ID_rd, ID_rd_rw));

  assign st_stall_s = ID_lop && busy_s && !done_s;
  assign hold_s     = load_stall_s || sb_stall_s || st_stall_s || !IF_valid || !MEM_valid;

  assign IF_stall       = hold_s;
  assign IF_ID_stall    = hold_s;
  assign ctrlBubble     = hold_s;
  assign EXEC_MEM_stall = !MEM_valid;
  assign IF_ID_flush    = JMP_ctrl || BRA_mispredict;
  assign EXEC_MEM_flush = BRA_mispredict;

  assign lop_busy = busy_s;
  assign lop_done = done_s;
  assign lop_rd   = lop_rd_r;

  // Long-op countdown; free-running through stalls and immune to flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      lop_rd_r <= X0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r  <= BUSY;
            cnt_r    <= lat_eff_s;
            lop_rd_r <= issue_rd;
          end else begin
            state_r  <= IDLE;
          end
        end
        BUSY: begin
          if (accept_s) begin
            cnt_r    <= lat_eff_s;
            lop_rd_r <= issue_rd;
          end else if (done_s) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
          end else begin
            cnt_r    <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= CNT_ZERO;
          lop_rd_r <= X0;
        end
      endcase
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the in-order pipeline: an N-source forwarding network, load-use and valid-based stall and flush generation, and a sequential scoreboard for one outstanding multi-cycle operation (mul/div-style long op). The long op issues from EXEC and writes the register file through its own port. The block sits beside the ID/EXEC/MEM/WB registers. It drives the forward-select muxes and the stall, flush and bubble controls.

## Interface
Parameters:
- `REG_W`, 5, register address width.
- `FWD_STAGES`, 2, number of forwarding sources. Index 0 is the youngest (MEM), index 1 is WB, and so on.
- `LAT_W`, 3, width of the long-op latency field and its counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `FWD_rd_rw`  in  FWD_STAGES  per-source register-write enable.
- `FWD_rd`  in  FWD_STAGES*REG_W  per-source destination. Source k occupies bits [k*REG_W +: REG_W].
- `EXEC_rs1`, `EXEC_rs2`  in  REG_W  EXEC source registers.
- `FWD_rs1`, `FWD_rs2`  out  FWD_STAGES  one-hot forward select. All zero selects the register-file value.
- `IF_ID_rs1`, `IF_ID_rs2`, `IF_ID_rd`  in  REG_W  ID-stage registers.
- `ID_rd_rw`  in  1  the ID instruction writes `IF_ID_rd`.
- `ID_lop`  in  1  the ID instruction is a long op.
- `EXEC_rd`  in  REG_W  EXEC destination.
- `EXEC_mem_read`  in  1  the EXEC instruction is a load.
- `BRA_mispredict`, `JMP_ctrl`, `IF_valid`, `MEM_valid`  in  1  pipeline status.
- `issue_valid`  in  1  a long op in EXEC is issuing this cycle.
- `issue_rd`  in  REG_W  long-op destination.
- `issue_lat`  in  LAT_W  cycles until writeback. A value of 0 is treated as 1.
- `IF_stall`, `IF_ID_stall`, `EXEC_MEM_stall`, `IF_ID_flush`, `EXEC_MEM_flush`, `ctrlBubble`  out  1  pipeline control.
- `lop_busy`  out  1  a long op is outstanding.
- `lop_done`  out  1  one-cycle writeback strobe for the long op.
- `lop_rd`  out  REG_W  destination of the outstanding long op.

## Operation
Forwarding:
- Source k matches an operand when `FWD_rd_rw[k]` is high, `FWD_rd[k]` equals the operand, and the operand is not 0.
- The lowest matching index wins. At most one select bit is high.
- x0 is never forwarded.

Load-use stall:
- `load_stall` = `EXEC_mem_read` && `EXEC_rd` != 0 && (`IF_ID_rs1` == `EXEC_rd` || `IF_ID_rs2` == `EXEC_rd`).

Long-op state machine, with states IDLE and BUSY and a down-counter `cnt`:
- IDLE → BUSY when `accept` is high. `cnt` loads max(`issue_lat`, 1) and `lop_rd` loads `issue_rd`.
- `accept` = `issue_valid` && !`EXEC_MEM_flush` && (IDLE || `lop_done`). An issue in BUSY without `lop_done` is ignored.
- In BUSY, `cnt` decrements every cycle. It does not freeze on pipeline stalls.
- `lop_done` = BUSY && `cnt` == 1.
- BUSY → IDLE after the `lop_done` cycle, unless `accept` is high in that same cycle. In that case the state stays BUSY and `cnt` and `lop_rd` reload (back-to-back issue).
- A flush never cancels an outstanding long op, because it is older than the branch.
- `lop_busy` = BUSY.

Scoreboard hazard `sb_stall`:
- Raised when the ID instruction touches a register the long op is writing. The match is against `lop_rd` while BUSY, or `issue_rd` while `accept` is high.
- For the `lop_rd` match, `lop_done` must be low. The register is free in the `lop_done` cycle itself, which relies on register-file write-through.
- For the `issue_rd` match, `issue_rd` must not be 0.
- "Touches" means `IF_ID_rs1` matches, `IF_ID_rs2` matches, or `ID_rd_rw` is high and `IF_ID_rd` matches. The `IF_ID_rd` case covers WAW.

Structural stall `st_stall`:
- `ID_lop` && BUSY && !`lop_done`.

Pipeline control outputs:
- `hold` = `load_stall` || `sb_stall` || `st_stall` || !`IF_valid` || !`MEM_valid`.
- `IF_stall` = `IF_ID_stall` = `ctrlBubble` = `hold`.
- `EXEC_MEM_stall` = !`MEM_valid`.
- `IF_ID_flush` = `JMP_ctrl` || `BRA_mispredict`.
- `EXEC_MEM_flush` = `BRA_mispredict`.

## Timing
Combinational outputs:
- Forward selects, stalls, flushes and `ctrlBubble` are combinational from inputs and state.
- With the state in reset, they depend only on the inputs.

Reset:
- `rst_n` low forces IDLE immediately, with `cnt`=0, `lop_rd`=0, `lop_busy`=0 and `lop_done`=0. This also applies mid-operation.
- `sb_stall` and `st_stall` then drop in the same cycle.

Long-op latency:
- An issue accepted at edge E0 with latency L gives `lop_busy`=1 from E0.
- `lop_done` is high during the L-th cycle after E0, that is, between edges E0+L-1 and E0+L.
- `lop_busy` falls at edge E0+L, unless a back-to-back issue is accepted.
- A dependent instruction in ID is held until the `lop_done` cycle, in which it is released and advances at edge E0+L.

## Test plan
- Forwarding priority: `FWD_rd_rw`=2'b11, MEM rd=5, WB rd=5, `EXEC_rs1`=5 → `FWD_rs1`=2'b01. With MEM rd=6 instead → 2'b10. With `EXEC_rs1`=0 and both sources at rd=0 → 2'b00.
- Load-use: `EXEC_mem_read`=1, `EXEC_rd`=7, `IF_ID_rs2`=7 → `IF_stall`, `IF_ID_stall` and `ctrlBubble` are 1. With `EXEC_rd`=0 → all 0.
- Long op with L=3, rd=9: the ID instruction reads x9 while BUSY → stalled for cycles 0–2 after issue. `lop_done` is high in cycle 3, during which the stall is already 0 and the instruction is released. `lop_busy` is 0 from cycle 4.
- Back-to-back and structural: with `ID_lop`=1 while BUSY, `st_stall` is high until the `lop_done` cycle. A second issue in the `lop_done` cycle with L=2 keeps `lop_busy`=1 and produces `lop_done` 2 cycles later.
- Flush: `issue_valid`=1 with `BRA_mispredict`=1 → no accept and `lop_busy` stays 0. A mispredict while BUSY → the countdown continues and `lop_done` still fires.
- Reset mid-op: L=7, deassert `rst_n` at cycle 2 → `lop_busy` and `sb_stall` go to 0 immediately, with no `lop_done` pulse.
